// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN frame sequencer: state codes and default timing parameters.
package cnn_pkg;

    localparam int TIMEOUT_CYC_DEF  = 200000;
    localparam int CLR_CYC_DEF      = 4;
    localparam int POOL2_PASSES_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_INPUT = 3'd2,
        ST_CONV1 = 3'd3,
        ST_CONV2 = 3'd4,
        ST_FC    = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } seq_state_e;

    // States in which the pipeline runs and the stage watchdog applies.
    function automatic logic is_stage(input seq_state_e s);
        return (s == ST_INPUT) || (s == ST_CONV1) || (s == ST_CONV2) || (s == ST_FC);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Per-state cycle timer: restarts on load, saturates at term and flags the terminal count.
module seq_timer #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (cnt != term) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller for the CNN pipeline: clears, walks the stages, watches for
// stalled stages and reports each classification result.
module cnn_frame_sequencer
    import cnn_pkg::*;
#(
    parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
    parameter int CLR_CYC      = CLR_CYC_DEF,
    parameter int POOL2_PASSES = POOL2_PASSES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        input_vald,
    input  logic        pool1_end,
    input  logic        pool2_end,
    input  logic        fc_valid,
    input  logic [4:0]  fc_data,
    output logic        pipe_en,
    output logic        pipe_clr_n,
    output logic        busy,
    output logic        done,
    output logic [4:0]  result,
    output logic        timeout_err,
    output logic [2:0]  stage,
    output logic [15:0] frame_cnt
);

    localparam int TW = $clog2(((TIMEOUT_CYC > CLR_CYC) ? TIMEOUT_CYC : CLR_CYC) + 1);
    localparam int PW = $clog2(POOL2_PASSES + 1);
    localparam logic [TW-1:0] TO_TERM  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] CLR_TERM = TW'(CLR_CYC - 1);
    localparam logic [PW-1:0] P2_LAST  = PW'(POOL2_PASSES - 1);

    seq_state_e    state;
    seq_state_e    nxt;
    logic [PW-1:0] p2_cnt;
    logic          to_hit;
    logic          tmr_tc;
    logic          tmr_load;
    logic [TW-1:0] tmr_term;

    // Priority: abort, then the stage's own event, then the watchdog.
    always_comb begin
        nxt    = state;
        to_hit = 1'b0;
        case (state)
            ST_IDLE:  if (start) nxt = ST_CLEAR;
            ST_CLEAR: if (tmr_tc) nxt = ST_INPUT;
            ST_INPUT: if (input_vald) nxt = ST_CONV1; else if (tmr_tc) to_hit = 1'b1;
            ST_CONV1: if (pool1_end) nxt = ST_CONV2; else if (tmr_tc) to_hit = 1'b1;
            ST_CONV2: if (pool2_end && (p2_cnt == P2_LAST)) nxt = ST_FC;
                      else if (tmr_tc) to_hit = 1'b1;
            ST_FC:    if (fc_valid) nxt = ST_DONE; else if (tmr_tc) to_hit = 1'b1;
            ST_DONE:  nxt = ST_IDLE;
            ST_ERR:   if (tmr_tc) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
        if (to_hit) nxt = ST_ERR;
        if (abort && (state != ST_IDLE) && (state != ST_ERR) && (state != ST_DONE)) begin
            nxt    = ST_ERR;
            to_hit = 1'b0;
        end
    end

    assign tmr_load = (nxt != state);
    assign tmr_term = ((state == ST_CLEAR) || (state == ST_ERR)) ? CLR_TERM : TO_TERM;

    seq_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .term  (tmr_term),
        .tc    (tmr_tc)
    );

    // Outputs are registered from the next state so they line up with stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pipe_en     <= 1'b0;
            pipe_clr_n  <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
            p2_cnt      <= '0;
        end else begin
            state      <= nxt;
            pipe_en    <= is_stage(nxt);
            pipe_clr_n <= !((nxt == ST_CLEAR) || (nxt == ST_ERR));
            busy       <= (nxt != ST_IDLE);
            done       <= (nxt == ST_DONE);
            if ((state == ST_IDLE) && start) begin
                timeout_err <= 1'b0;
            end else if (to_hit) begin
                timeout_err <= 1'b1;
            end
            if ((state == ST_FC) && (nxt == ST_DONE)) begin
                result    <= fc_data;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if ((nxt == ST_CONV2) && (state != ST_CONV2)) begin
                p2_cnt <= '0;
            end else if ((state == ST_CONV2) && pool2_end) begin
                p2_cnt <= p2_cnt + 1'b1;
            end
        end
    end

    assign stage = state;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed plus randomized bench for cnn_frame_sequencer with a frame-level reference model.
module tb_cnn_frame_sequencer;

    localparam int TO  = 500;
    localparam int CLR = 4;
    localparam int P2  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        input_vald = 1'b0;
    logic        pool1_end = 1'b0;
    logic        pool2_end = 1'b0;
    logic        fc_valid = 1'b0;
    logic [4:0]  fc_data = '0;
    logic        pipe_en;
    logic        pipe_clr_n;
    logic        busy;
    logic        done;
    logic [4:0]  result;
    logic        timeout_err;
    logic [2:0]  stage;
    logic [15:0] frame_cnt;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    bit          spur_en = 1'b0;
    logic [15:0] exp_cnt = '0;
    logic [4:0]  exp_res = '0;

    cnn_frame_sequencer #(
        .TIMEOUT_CYC  (TO),
        .CLR_CYC      (CLR),
        .POOL2_PASSES (P2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .input_vald  (input_vald),
        .pool1_end   (pool1_end),
        .pool2_end   (pool2_end),
        .fc_valid    (fc_valid),
        .fc_data     (fc_data),
        .pipe_en     (pipe_en),
        .pipe_clr_n  (pipe_clr_n),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .timeout_err (timeout_err),
        .stage       (stage),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_pipe_en"}, pipe_en, 0);
        chk({tag, "_pipe_clr_n"}, pipe_clr_n, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pipe_en"}, pipe_en, 0);
        chk({tag, "_pipe_clr_n"}, pipe_clr_n, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
    endtask

    task automatic clr_in;
        start = 1'b0;
        input_vald = 1'b0;
        pool1_end = 1'b0;
        pool2_end = 1'b0;
        fc_valid = 1'b0;
    endtask

    // Drive only events the given stage does not expect; they must change nothing.
    task automatic spur(input int st);
        if (spur_en) begin
            case (st)
                2: begin pool1_end = 1'($urandom_range(0, 1)); pool2_end = 1'($urandom_range(0, 1));
                         fc_valid = 1'($urandom_range(0, 1)); end
                3: begin input_vald = 1'($urandom_range(0, 1)); pool2_end = 1'($urandom_range(0, 1));
                         fc_valid = 1'($urandom_range(0, 1)); end
                4: begin input_vald = 1'($urandom_range(0, 1)); pool1_end = 1'($urandom_range(0, 1));
                         fc_valid = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1)); end
                5: begin input_vald = 1'($urandom_range(0, 1)); pool1_end = 1'($urandom_range(0, 1));
                         pool2_end = 1'($urandom_range(0, 1)); end
                default: ;
            endcase
        end
    endtask

    task automatic dwell(input int st, input int n);
        for (int i = 0; i < n; i++) begin
            spur(st);
            tick;
            clr_in();
            chk($sformatf("dwell_st%0d", st), stage, st);
            chk("dwell_no_done", done, 0);
        end
    endtask

    task automatic begin_frame;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_clears_to_err", timeout_err, 0);
        for (int i = 0; i < CLR; i++) begin
            chk("clear_stage", stage, 1);
            chk("clear_clr_n", pipe_clr_n, 0);
            chk("clear_pipe_en", pipe_en, 0);
            chk("clear_busy", busy, 1);
            tick;
        end
        chk("input_stage", stage, 2);
        chk("input_pipe_en", pipe_en, 1);
        chk("input_clr_n", pipe_clr_n, 1);
    endtask

    task automatic to_conv1(input int g);
        dwell(2, g);
        input_vald = 1'b1;
        tick;
        input_vald = 1'b0;
        chk("conv1_stage", stage, 3);
    endtask

    task automatic to_conv2(input int g);
        dwell(3, g);
        pool1_end = 1'b1;
        tick;
        pool1_end = 1'b0;
        chk("conv2_stage", stage, 4);
        chk("conv2_pipe_en", pipe_en, 1);
    endtask

    task automatic to_fc(input int g);
        for (int i = 0; i < P2; i++) begin
            dwell(4, g);
            pool2_end = 1'b1;
            tick;
            pool2_end = 1'b0;
            chk($sformatf("pool2_pass%0d", i), stage, (i == P2 - 1) ? 5 : 4);
        end
    endtask

    task automatic finish_frame(input int g, input logic [4:0] d);
        dwell(5, g);
        fc_valid = 1'b1;
        fc_data = d;
        tick;
        fc_valid = 1'b0;
        fc_data = 5'($urandom_range(0, 31));
        exp_cnt = exp_cnt + 16'd1;
        exp_res = d;
        chk("done_stage", stage, 6);
        chk("done_pulse", done, 1);
        chk("done_result", result, exp_res);
        chk("done_frame_cnt", frame_cnt, exp_cnt);
        chk("done_pipe_en", pipe_en, 0);
        chk("done_busy", busy, 1);
        tick;
        chk_idle("after_done");
        chk("after_done_result", result, exp_res);
    endtask

    task automatic err_window(input string tag, input logic exp_to);
        for (int i = 0; i < CLR; i++) begin
            chk({tag, "_stage"}, stage, 7);
            chk({tag, "_clr_n"}, pipe_clr_n, 0);
            chk({tag, "_pipe_en"}, pipe_en, 0);
            chk({tag, "_timeout_err"}, timeout_err, exp_to);
            chk({tag, "_no_done"}, done, 0);
            tick;
        end
        chk_idle({tag, "_idle"});
        chk({tag, "_to_sticky"}, timeout_err, exp_to);
    endtask

    initial begin
        // Reset values
        repeat (3) tick;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick;
        chk_idle("post_reset");

        // Nominal frame with fixed event spacing and result 7
        begin_frame();
        to_conv1(4);
        to_conv2(89);
        to_fc(99);
        finish_frame(99, 5'd7);
        repeat (2) tick;
        chk("nominal_pipe_en_low", pipe_en, 0);

        // Random frames with unexpected events sprinkled in every stage
        spur_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            begin_frame();
            to_conv1($urandom_range(0, 30));
            to_conv2($urandom_range(0, 60));
            to_fc($urandom_range(0, 40));
            finish_frame($urandom_range(0, 30), 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 3)) tick;
        end

        // pool1_end on the same edge as the watchdog terminal count: transition wins
        begin_frame();
        to_conv1(1);
        to_conv2(TO - 1);
        to_fc(2);
        finish_frame(3, 5'd21);

        // Watchdog expiry in CONV1
        begin_frame();
        to_conv1(3);
        dwell(3, TO - 1);
        tick;
        chk("timeout_busy", busy, 1);
        err_window("timeout", 1'b1);
        repeat (3) tick;
        chk("timeout_err_held", timeout_err, 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("restart_stage", stage, 1);
        chk("restart_clears_to_err", timeout_err, 0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        err_window("abort_clear", 1'b0);

        // Abort together with pool1_end lands in ERR, not CONV2
        begin_frame();
        to_conv1(2);
        dwell(3, 5);
        abort = 1'b1;
        pool1_end = 1'b1;
        tick;
        abort = 1'b0;
        pool1_end = 1'b0;
        err_window("abort_pool1", 1'b0);

        // Reset asserted while in FC
        begin_frame();
        to_conv1(2);
        to_conv2(3);
        to_fc(1);
        dwell(5, 3);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        exp_res = '0;
        chk_reset_vals("reset_in_fc");
        tick;
        chk("reset_in_fc_no_done", done, 0);
        rst_n = 1'b1;
        tick;
        chk_idle("reset_in_fc_recover");
        chk("reset_in_fc_result", result, 0);

        // Frame counter wrap from 0xFFFF
        spur_en = 1'b0;
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        exp_cnt = 16'hFFFF;
        tick;
        chk("preload_cnt", frame_cnt, exp_cnt);
        begin_frame();
        to_conv1(1);
        to_conv2(1);
        to_fc(1);
        finish_frame(1, 5'd30);
        chk("wrap_cnt_zero", frame_cnt, 16'h0000);

        repeat (4) tick;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
